// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state encoding for the SPI transaction controller
package spi_pkg;

    localparam int WIDTH_DEF = 8;
    localparam logic READ = 1'b1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GET_ADDR   = 3'd1,
        LATCH_ADDR = 3'd2,
        READ_LOAD  = 3'd3,
        READ_SHIFT = 3'd4,
        WRITE_GET  = 3'd5,
        WRITE_MEM  = 3'd6,
        DONE       = 3'd7
    } state_t;

endpackage

// File: rtl/spi_bit_counter.sv
// rtl/spi_bit_counter.sv - SCLK edge counter; terminal flags the WIDTH-th counted edge
module spi_bit_counter #(
    parameter int WIDTH = spi_pkg::WIDTH_DEF,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic terminal
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Combinational on inc so the state change lands on the same clk as the last edge.
    assign terminal = inc && (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/spi_fsm.sv
// rtl/spi_fsm.sv - SPI memory transaction controller; Moore strobes for address latch, load, write, MISO enable
module spi_fsm
    import spi_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sclkPosEdge,
    input  logic sclkNegEdge,
    input  logic csConditioned,
    input  logic rwBit,
    output logic addrWe,
    output logic srWe,
    output logic dmWe,
    output logic misoBufe
);

    state_t r_state;
    state_t w_next;
    logic   w_inc;
    logic   w_clear;
    logic   w_terminal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Only the edge relevant to the current state is counted; the other is dropped.
    always_comb begin
        w_inc = 1'b0;
        case (r_state)
            GET_ADDR, WRITE_GET: w_inc = sclkPosEdge;
            READ_SHIFT:          w_inc = sclkNegEdge;
            default:             w_inc = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (!csConditioned) w_next = GET_ADDR;
            GET_ADDR:   if (w_terminal) w_next = LATCH_ADDR;
            LATCH_ADDR: w_next = (rwBit == READ) ? READ_LOAD : WRITE_GET;
            READ_LOAD:  w_next = READ_SHIFT;
            READ_SHIFT: if (w_terminal) w_next = DONE;
            WRITE_GET:  if (w_terminal) w_next = WRITE_MEM;
            WRITE_MEM:  w_next = DONE;
            DONE:       w_next = DONE;
            default:    w_next = IDLE;
        endcase
        if (csConditioned) w_next = IDLE;
    end

    assign w_clear = csConditioned || (w_next != r_state);

    spi_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .inc      (w_inc),
        .terminal (w_terminal)
    );

    assign addrWe   = (r_state == LATCH_ADDR);
    assign srWe     = (r_state == READ_LOAD);
    assign dmWe     = (r_state == WRITE_MEM);
    assign misoBufe = (r_state == READ_SHIFT);

endmodule

// File: tb/tb_spi_fsm.sv
// tb/tb_spi_fsm.sv - self-checking bench for spi_fsm: vector table, directed corners, random vs timestamp model
module tb_spi_fsm;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    logic sclkPosEdge;
    logic sclkNegEdge;
    logic csConditioned;
    logic rwBit;
    logic addrWe;
    logic srWe;
    logic dmWe;
    logic misoBufe;

    spi_fsm #(.WIDTH(W), .CNT_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .sclkPosEdge   (sclkPosEdge),
        .sclkNegEdge   (sclkNegEdge),
        .csConditioned (csConditioned),
        .rwBit         (rwBit),
        .addrWe        (addrWe),
        .srWe          (srWe),
        .dmWe          (dmWe),
        .misoBufe      (misoBufe)
    );

    always #5 clk = ~clk;

    // Output nibble order: {addrWe, srWe, dmWe, misoBufe}
    typedef struct {
        logic       rst;
        logic       cs;
        logic       p;
        logic       n;
        logic       rw;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Frame model in terms of cycle timestamps of the counted edges.
    int t = 0;
    bit in_frame = 1'b0;
    int t0 = 0;
    int pos_a = 0;
    int t_addr = -1;
    bit rd = 1'b0;
    int pos_w = 0;
    int t_w = -1;
    int neg_r = 0;
    int t_r = -1;

    function automatic logic [3:0] model_exp();
        logic a, s, d, m;
        a = in_frame && t_addr >= 0 && t == t_addr + 1;
        s = in_frame && t_addr >= 0 && rd && t == t_addr + 2;
        d = in_frame && t_w >= 0 && t == t_w + 1;
        m = in_frame && t_addr >= 0 && rd && t >= t_addr + 3 && (t_r < 0 || t <= t_r);
        return {a, s, d, m};
    endfunction

    task automatic model_update(input logic rst, input logic cs, input logic p,
                                input logic n, input logic rw);
        if (in_frame && t >= t0) begin
            if (t_addr < 0) begin
                if (p) begin
                    pos_a++;
                    if (pos_a == W) t_addr = t;
                end
            end else if (t == t_addr + 1) begin
                rd = rw;
            end else if (!rd && t >= t_addr + 2 && t_w < 0) begin
                if (p) begin
                    pos_w++;
                    if (pos_w == W) t_w = t;
                end
            end else if (rd && t >= t_addr + 3 && t_r < 0) begin
                if (n) begin
                    neg_r++;
                    if (neg_r == W) t_r = t;
                end
            end
        end
        if (rst || cs) begin
            in_frame = 1'b0;
            pos_a = 0; t_addr = -1; rd = 1'b0;
            pos_w = 0; t_w = -1; neg_r = 0; t_r = -1;
        end else if (!in_frame) begin
            in_frame = 1'b1;
            t0 = t + 1;
        end
    endtask

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got {addrWe,srWe,dmWe,misoBufe}=%b want %b", nm, t, got, exp);
        end
    endtask

    // One clk: drive inputs, sample at the falling edge, check against the model.
    task automatic step(input logic rst, input logic cs, input logic p, input logic n,
                        input logic rw, output logic [3:0] o);
        reset = rst; csConditioned = cs; sclkPosEdge = p; sclkNegEdge = n; rwBit = rw;
        @(negedge clk);
        o = {addrWe, srWe, dmWe, misoBufe};
        if (chk_en) chk("model", o, model_exp());
        model_update(rst, cs, p, n, rw);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic add(input int k, input logic rst, input logic cs, input logic p,
                       input logic n, input logic rw, input logic [3:0] exp);
        vec_t v;
        v.rst = rst; v.cs = cs; v.p = p; v.n = n; v.rw = rw; v.exp = exp;
        for (int i = 0; i < k; i++) tbl.push_back(v);
    endtask

    // From IDLE with CS about to fall: enter GET_ADDR and deliver the 8 address posedges.
    task automatic frame_addr(input logic rw);
        logic [3:0] o;
        step(0, 0, 0, 0, rw, o);
        for (int i = 0; i < W; i++) begin
            step(0, 0, 1, 0, rw, o);
            chk("addr_quiet", o, 4'b0000);
        end
    endtask

    task automatic read_frame();
        logic [3:0] o;
        frame_addr(1'b1);
        step(0, 0, 0, 0, 1, o); chk("rd_addrWe", o, 4'b1000);
        step(0, 0, 0, 1, 1, o); chk("rd_srWe", o, 4'b0100);
        for (int i = 0; i < W; i++) begin
            step(0, 0, 0, 1, 1, o); chk("rd_miso", o, 4'b0001);
        end
        step(0, 0, 0, 1, 1, o); chk("rd_done", o, 4'b0000);
    endtask

    task automatic write_frame();
        logic [3:0] o;
        frame_addr(1'b0);
        step(0, 0, 0, 0, 0, o); chk("wr_addrWe", o, 4'b1000);
        for (int i = 0; i < W; i++) begin
            step(0, 0, 1, 1, 0, o); chk("wr_get", o, 4'b0000);
        end
        step(0, 0, 0, 0, 0, o); chk("wr_dmWe", o, 4'b0010);
        step(0, 0, 0, 0, 0, o); chk("wr_done", o, 4'b0000);
    endtask

    initial begin
        logic [3:0] o;
        logic       cs_lvl;
        int         r;

        reset = 1'b1; csConditioned = 1'b0; sclkPosEdge = 1'b0;
        sclkNegEdge = 1'b0; rwBit = 1'b0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, o);

        // Reset release with CS low, then a complete write frame.
        add(1, 1, 0, 0, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b0000);
        add(7, 0, 0, 1, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 1, 0, 4'b0000);
        add(1, 0, 0, 1, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b1000);
        add(8, 0, 0, 1, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 0, 4'b0010);
        add(2, 0, 0, 1, 0, 0, 4'b0000);
        add(1, 0, 1, 0, 0, 0, 4'b0000);
        add(1, 0, 1, 1, 1, 0, 4'b0000);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].cs, tbl[i].p, tbl[i].n, tbl[i].rw, o);
            chk($sformatf("tbl[%0d]", i), o, tbl[i].exp);
        end

        // Read frame, then CS high.
        read_frame();
        step(0, 1, 0, 0, 0, o); chk("rd_cs_high", o, 4'b0000);

        // CS abort after 4 address posedges, then a normal write frame.
        step(0, 0, 0, 0, 0, o);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, o);
        step(0, 1, 0, 0, 0, o); chk("abort_edge", o, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 0, o); chk("abort_idle", o, 4'b0000);
        end
        write_frame();
        step(0, 1, 0, 0, 0, o); chk("wr_cs_high", o, 4'b0000);

        // Reset while in READ_SHIFT.
        frame_addr(1'b1);
        step(0, 0, 0, 0, 1, o);
        step(0, 0, 0, 0, 1, o);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, o);
        step(1, 1, 0, 1, 1, o); chk("rst_in_shift", o, 4'b0001);
        step(0, 1, 1, 0, 1, o); chk("rst_after", o, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, i[0], ~i[0], 1, o); chk("rst_cs_high", o, 4'b0000);
        end

        // Edges while in DONE, then CS cycle and a new read frame.
        write_frame();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 1, o); chk("done_edges", o, 4'b0000);
        end
        step(0, 1, 0, 0, 0, o); chk("done_cs_high", o, 4'b0000);
        read_frame();
        step(0, 1, 0, 0, 0, o);

        // Random traffic against the model, including simultaneous edges.
        cs_lvl = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (cs_lvl) cs_lvl = ($urandom_range(0, 3) != 0);
            else        cs_lvl = ($urandom_range(0, 59) == 0);
            r = $urandom_range(0, 7);
            step(($urandom_range(0, 199) == 0), cs_lvl,
                 (r <= 2 || r == 6), ((r >= 3 && r <= 5) || r == 6),
                 1'($urandom_range(0, 1)), o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
